crossing_decision: RTL and testbench
====================================

CROSSING_DECISION -- requirements
Module: crossing_decision

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 320, frame width in pixels.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 240, frame height in pixels.
REQ-003 The block SHALL have parameter WINDOW, default 8, number of most recent frame verdicts kept (2..15).
REQ-004 The block SHALL have parameter ON_VOTES, default 6, positive votes needed to assert stop.
REQ-005 The block SHALL have parameter OFF_VOTES, default 2, vote level at or below which release starts.
REQ-006 The block SHALL have parameter HOLD_FRAMES, default 30, frames stop is held after release starts.
REQ-007 The block SHALL have parameters WHITE_MIN, default 2000, and WHITE_MAX, default 40000, which give the plausible white-pixel band.
REQ-008 The block SHALL have parameter TIMEOUT_CYCLES, default 1680000, clk cycles without a verdict before the block declares the input stale.
REQ-009 The block SHALL have port clk, input, 1 bit, the single clock used for all logic.
REQ-010 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-011 The block SHALL have port det_valid, input, 1 bit, a one-cycle pulse per frame verdict from pattern_recognition.
REQ-012 The block SHALL have port det_crossing, input, 1 bit, the raw crossing verdict, qualified by det_valid.
REQ-013 The block SHALL have port white_count, input, CW = $clog2(IMG_WIDTH*IMG_HEIGHT) bits, white-pixel count, qualified by det_valid.
REQ-014 The block SHALL have port clear, input, 1 bit, a synchronous flush request.
REQ-015 The block SHALL have port stop, output, 1 bit, the debounced zebra-crossing stop command.
REQ-016 The block SHALL have port stop_valid, output, 1 bit, a one-cycle pulse when stop reflects a new verdict.
REQ-017 The block SHALL have port vote_count, output, 4 bits, the number of positive samples in the window.
REQ-018 The block SHALL have port state, output, 3 bits, the current FSM state encoding.
REQ-019 The block SHALL have port stale, output, 1 bit, which is high while the input is timed out.

Function
REQ-020 A sample SHALL be 1 iff det_crossing=1 and WHITE_MIN <= white_count <= WHITE_MAX (unsigned compare), and 0 otherwise.
REQ-021 On det_valid, history SHALL shift in the sample (WINDOW bits); vote_count SHALL update incrementally as +new sample, minus the bit dropped, registered one cycle later.
REQ-022 A fill counter SHALL count accepted samples, saturating at WINDOW.
REQ-023 The FSM SHALL have states FILL=0, CLEAR=1, STOP=2, HOLD=3; the SHALL be no other reachable states.
REQ-024 In FILL, on the sample that brings fill to WINDOW, the FSM SHALL go to STOP if the updated votes >= ON_VOTES, and otherwise to CLEAR.
REQ-025 CLEAR SHALL go to STOP when the updated votes >= ON_VOTES.
REQ-026 STOP SHALL go to HOLD when the updated votes <= OFF_VOTES, loading hold_cnt = HOLD_FRAMES-1.
REQ-027 In HOLD, each det_valid SHALL re-enter STOP if votes >= ON_VOTES; otherwise, if hold_cnt=0, the FSM SHALL go to CLEAR; otherwise hold_cnt SHALL decrement.
REQ-028 Votes strictly between OFF_VOTES and ON_VOTES SHALL cause no transition (hysteresis).
REQ-029 stop SHALL be 1 exactly in STOP and HOLD, registered.
REQ-030 stop and state SHALL change in the cycle after the det_valid that causes the change.
REQ-031 stop_valid SHALL pulse one cycle after every accepted det_valid whose state is not FILL after the update.
REQ-032 A timeout counter SHALL reset on det_valid and otherwise increment.
REQ-033 When the timeout counter reaches TIMEOUT_CYCLES-1, the block SHALL set stale=1, go to FILL, and zero the history, votes and fill; stop SHALL be 0 next cycle.
REQ-034 stale SHALL clear on the next det_valid, and that sample SHALL be accepted normally.
REQ-035 If det_valid and timeout expiry occur in the same cycle, det_valid SHALL win.
REQ-036 If clear=1, the block SHALL perform the same flush as timeout, except that stale=0; clear SHALL take priority over a simultaneous det_valid, which is discarded.
REQ-037 Inputs SHALL be ignored when det_valid=0; there is no backpressure.
REQ-038 The parameter constraint OFF_VOTES < ON_VOTES <= WINDOW SHALL be checked at elaboration.

Reset
REQ-039 On rst=1 at a clk edge: state=FILL; stop=0; stop_valid=0; vote_count=0; stale=0; history, fill, hold and timeout counters=0.
REQ-040 Reset SHALL take priority over clear, det_valid and timeout.
REQ-041 A reset mid-HOLD SHALL drop stop the next cycle.

Verification
REQ-042 The bench SHALL cover: 8 verdicts of crossing=1, white=10000 -> stop=1 one cycle after 8th pulse, vote_count=8, state=2; no stop_valid before the 8th pulse.
REQ-043 The bench SHALL cover: 8 positive verdicts, then alternating 1/0 holding votes at 4..5 -> stop remains 1, state=2 (hysteresis).
REQ-044 The bench SHALL cover, with HOLD_FRAMES=3: after STOP, 6 negative verdicts -> HOLD entered at votes=2; 3 further negatives -> CLEAR, stop=0; a positive burst reaching 6 votes inside HOLD -> back to STOP.
REQ-045 The bench SHALL cover: crossing=1 with white_count=100 and with 50000 -> sample=0, vote_count unchanged at 0.
REQ-046 The bench SHALL cover, with TIMEOUT_CYCLES=100: in STOP, no det_valid for 100 cycles -> stale=1, stop=0, state=0, vote_count=0; next det_valid -> stale=0.
REQ-047 The bench SHALL cover: clear and det_valid in the same cycle while in STOP -> FILL, stop=0, sample discarded (fill=0), stale=0.

Source files
------------

// File: rtl/crossing_decision.sv
// Debounces per-frame zebra-crossing verdicts into a stop command using a
// sliding vote window, on/off hysteresis, a hold-off period and an input-stale timeout.
module crossing_decision #(
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int WINDOW         = 8,
  parameter int ON_VOTES       = 6,
  parameter int OFF_VOTES      = 2,
  parameter int HOLD_FRAMES    = 30,
  parameter int WHITE_MIN      = 2000,
  parameter int WHITE_MAX      = 40000,
  parameter int TIMEOUT_CYCLES = 1680000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  det_valid,
  input  logic                                  det_crossing,
  input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] white_count,
  input  logic                                  clear,
  output logic                                  stop,
  output logic                                  stop_valid,
  output logic [3:0]                            vote_count,
  output logic [2:0]                            state,
  output logic                                  stale
);

  localparam int CW = $clog2(IMG_WIDTH*IMG_HEIGHT);
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [3:0]    WIN_V     = 4'(WINDOW);
  localparam logic [3:0]    ON_V      = 4'(ON_VOTES);
  localparam logic [3:0]    OFF_V     = 4'(OFF_VOTES);
  localparam logic [31:0]   WMIN      = 32'(WHITE_MIN);
  localparam logic [31:0]   WMAX      = 32'(WHITE_MAX);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  if (WINDOW < 2 || WINDOW > 15) begin : g_chk_window
    $error("crossing_decision: WINDOW must lie in 2..15");
  end
  if (!(OFF_VOTES < ON_VOTES && ON_VOTES <= WINDOW)) begin : g_chk_votes
    $error("crossing_decision: need OFF_VOTES < ON_VOTES <= WINDOW");
  end
  if (HOLD_FRAMES < 1 || TIMEOUT_CYCLES < 1) begin : g_chk_counts
    $error("crossing_decision: HOLD_FRAMES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    CLEAR = 3'd1,
    STOP  = 3'd2,
    HOLD  = 3'd3
  } state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= WIN_V) ? WIN_V : v + 4'd1;
  endfunction

  state_t            state_q, state_d;
  logic [WINDOW-1:0] hist_q, hist_d;
  logic [3:0]        votes_q, votes_d;
  logic [3:0]        fill_q, fill_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [TW-1:0]     to_q, to_d;
  logic              stop_q, stop_d;
  logic              sv_q, sv_d;
  logic              stale_q, stale_d;

  logic [31:0] wc_ext;
  logic        sample;
  logic        drop;
  logic        expire;
  logic [3:0]  votes_upd;
  logic [3:0]  fill_upd;

  assign wc_ext    = {{(32-CW){1'b0}}, white_count};
  assign sample    = det_crossing && (wc_ext >= WMIN) && (wc_ext <= WMAX);
  assign drop      = hist_q[WINDOW-1];
  assign votes_upd = votes_q + {3'b000, sample} - {3'b000, drop};
  assign fill_upd  = sat_inc(fill_q);
  // A verdict arriving in the expiry cycle keeps the input alive.
  assign expire    = !det_valid && (to_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    votes_d = votes_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    to_d    = to_q + TW'(1);
    stale_d = stale_q;
    sv_d    = 1'b0;

    if (clear) begin
      state_d = FILL;
      hist_d  = '0;
      votes_d = '0;
      fill_d  = '0;
      hold_d  = '0;
      to_d    = '0;
      stale_d = 1'b0;
    end else if (det_valid) begin
      hist_d  = {hist_q[WINDOW-2:0], sample};
      votes_d = votes_upd;
      fill_d  = fill_upd;
      to_d    = '0;
      stale_d = 1'b0;
      case (state_q)
        FILL: begin
          if (fill_upd == WIN_V) begin
            state_d = (votes_upd >= ON_V) ? STOP : CLEAR;
          end
        end
        CLEAR: begin
          if (votes_upd >= ON_V) begin
            state_d = STOP;
          end
        end
        STOP: begin
          if (votes_upd <= OFF_V) begin
            state_d = HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (votes_upd >= ON_V) begin
            state_d = STOP;
          end else if (hold_q == '0) begin
            state_d = CLEAR;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: state_d = FILL;
      endcase
      sv_d = (state_d != FILL);
    end else if (expire) begin
      state_d = FILL;
      hist_d  = '0;
      votes_d = '0;
      fill_d  = '0;
      hold_d  = '0;
      to_d    = '0;
      stale_d = 1'b1;
    end

    stop_d = (state_d == STOP) || (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      hist_q  <= '0;
      votes_q <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      to_q    <= '0;
      stop_q  <= 1'b0;
      sv_q    <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      votes_q <= votes_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      stop_q  <= stop_d;
      sv_q    <= sv_d;
      stale_q <= stale_d;
    end
  end

  assign stop       = stop_q;
  assign stop_valid = sv_q;
  assign vote_count = votes_q;
  assign state      = state_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_crossing_decision.sv
// Directed bench for crossing_decision: two instances share stimulus, one with a
// short hold period and one with a longer hold so HOLD can be re-entered into STOP.
module tb_crossing_decision;

  logic        clk;
  logic        rst;
  logic        det_valid;
  logic        det_crossing;
  logic [16:0] white_count;
  logic        clear;

  logic        stop, stop_valid, stale;
  logic [3:0]  vote_count;
  logic [2:0]  state;
  logic        stop_h, stop_valid_h, stale_h;
  logic [3:0]  vote_count_h;
  logic [2:0]  state_h;

  int n_cmp;
  int n_fail;

  crossing_decision #(
    .WINDOW(8), .ON_VOTES(6), .OFF_VOTES(2), .HOLD_FRAMES(3), .TIMEOUT_CYCLES(100)
  ) u_dut (
    .clk(clk), .rst(rst), .det_valid(det_valid), .det_crossing(det_crossing),
    .white_count(white_count), .clear(clear), .stop(stop), .stop_valid(stop_valid),
    .vote_count(vote_count), .state(state), .stale(stale)
  );

  crossing_decision #(
    .WINDOW(8), .ON_VOTES(6), .OFF_VOTES(2), .HOLD_FRAMES(8), .TIMEOUT_CYCLES(100)
  ) u_dut_h (
    .clk(clk), .rst(rst), .det_valid(det_valid), .det_crossing(det_crossing),
    .white_count(white_count), .clear(clear), .stop(stop_h), .stop_valid(stop_valid_h),
    .vote_count(vote_count_h), .state(state_h), .stale(stale_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge with the update visible.
  task automatic send(input logic c, input int w);
    det_valid    = 1'b1;
    det_crossing = c;
    white_count  = 17'(w);
    @(negedge clk);
    det_valid    = 1'b0;
    det_crossing = 1'b0;
    white_count  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b1; det_valid = 1'b1; det_crossing = 1'b1; white_count = 17'd10000;
    repeat (2) @(negedge clk);
    rst = 1'b0; clear = 1'b0; det_valid = 1'b0; det_crossing = 1'b0; white_count = '0;
    n_cmp++;
    if ({state, stop, stop_valid, vote_count, stale} !== {3'd0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: state/stop/sv/votes/stale got %0d/%0b/%0b/%0d/%0b want 0/0/0/0/0",
               state, stop, stop_valid, vote_count, stale);
    end
    n_cmp++;
    if ({state_h, stop_h, vote_count_h} !== {3'd0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_h: state/stop/votes got %0d/%0b/%0d want 0/0/0", state_h, stop_h, vote_count_h);
    end
  endtask

  task automatic test_fill_stop();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      send(1'b1, 10000);
      n_cmp++;
      if ({state, stop, stop_valid, vote_count} !== {3'd0, 1'b0, 1'b0, 4'(i)}) begin
        n_fail++;
        $display("FAIL fill_%0d: state/stop/sv/votes got %0d/%0b/%0b/%0d want 0/0/0/%0d",
                 i, state, stop, stop_valid, vote_count, i);
      end
    end
    send(1'b1, 10000);
    n_cmp++;
    if ({state, stop, stop_valid, vote_count} !== {3'd2, 1'b1, 1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL fill_stop: state/stop/sv/votes got %0d/%0b/%0b/%0d want 2/1/1/8",
               state, stop, stop_valid, vote_count);
    end
    @(negedge clk);
    n_cmp++;
    if ({stop, stop_valid} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sv_pulse: stop/sv got %0b/%0b want 1/0", stop, stop_valid);
    end
  endtask

  task automatic test_hysteresis();
    int ev[12] = '{7, 7, 6, 6, 5, 5, 4, 4, 4, 4, 4, 4};
    for (int i = 0; i < 12; i++) begin
      send(logic'(i % 2), 10000);
      n_cmp++;
      if ({state, stop, stop_valid, vote_count} !== {3'd2, 1'b1, 1'b1, 4'(ev[i])}) begin
        n_fail++;
        $display("FAIL hyst_%0d: state/stop/sv/votes got %0d/%0b/%0b/%0d want 2/1/1/%0d",
                 i, state, stop, stop_valid, vote_count, ev[i]);
      end
    end
  endtask

  task automatic test_hold();
    int eh[5] = '{2, 2, 3, 4, 5};
    do_reset();
    repeat (8) send(1'b1, 10000);
    for (int i = 1; i <= 5; i++) begin
      send(1'b0, 10000);
      n_cmp++;
      if ({state, stop, vote_count} !== {3'd2, 1'b1, 4'(8 - i)}) begin
        n_fail++;
        $display("FAIL hold_dec_%0d: state/stop/votes got %0d/%0b/%0d want 2/1/%0d",
                 i, state, stop, vote_count, 8 - i);
      end
    end
    send(1'b0, 10000);
    n_cmp++;
    if ({state, stop, vote_count, state_h} !== {3'd3, 1'b1, 4'd2, 3'd3}) begin
      n_fail++;
      $display("FAIL hold_enter: state/stop/votes/state_h got %0d/%0b/%0d/%0d want 3/1/2/3",
               state, stop, vote_count, state_h);
    end
    for (int i = 1; i <= 2; i++) begin
      send(1'b0, 10000);
      n_cmp++;
      if ({state, stop, vote_count} !== {3'd3, 1'b1, 4'(2 - i)}) begin
        n_fail++;
        $display("FAIL hold_cnt_%0d: state/stop/votes got %0d/%0b/%0d want 3/1/%0d",
                 i, state, stop, vote_count, 2 - i);
      end
    end
    send(1'b0, 10000);
    n_cmp++;
    if ({state, stop, stop_valid, vote_count} !== {3'd1, 1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL hold_release: state/stop/sv/votes got %0d/%0b/%0b/%0d want 1/0/1/0",
               state, stop, stop_valid, vote_count);
    end

    do_reset();
    repeat (8) send(1'b1, 10000);
    repeat (6) send(1'b0, 10000);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 10000);
      n_cmp++;
      if ({state_h, stop_h, vote_count_h} !== {3'd3, 1'b1, 4'(eh[i])}) begin
        n_fail++;
        $display("FAIL rehold_%0d: state/stop/votes got %0d/%0b/%0d want 3/1/%0d",
                 i, state_h, stop_h, vote_count_h, eh[i]);
      end
    end
    send(1'b1, 10000);
    n_cmp++;
    if ({state_h, stop_h, vote_count_h} !== {3'd2, 1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL restop: state/stop/votes got %0d/%0b/%0d want 2/1/6", state_h, stop_h, vote_count_h);
    end
  endtask

  task automatic test_white_band();
    int   wv[7] = '{100, 50000, 2000, 40000, 1999, 40001, 10000};
    logic cv[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int   ev[7] = '{0, 0, 1, 2, 2, 2, 2};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(cv[i], wv[i]);
      n_cmp++;
      if ({state, stop_valid, vote_count} !== {3'd0, 1'b0, 4'(ev[i])}) begin
        n_fail++;
        $display("FAIL white_%0d: state/sv/votes got %0d/%0b/%0d want 0/0/%0d",
                 wv[i], state, stop_valid, vote_count, ev[i]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (8) send(1'b1, 10000);
    repeat (99) @(negedge clk);
    n_cmp++;
    if ({stale, stop, state} !== {1'b0, 1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL to_early: stale/stop/state got %0b/%0b/%0d want 0/1/2", stale, stop, state);
    end
    @(negedge clk);
    n_cmp++;
    if ({stale, stop, state, vote_count} !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL to_expire: stale/stop/state/votes got %0b/%0b/%0d/%0d want 1/0/0/0",
               stale, stop, state, vote_count);
    end
    send(1'b1, 10000);
    n_cmp++;
    if ({stale, state, stop_valid, vote_count} !== {1'b0, 3'd0, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL to_recover: stale/state/sv/votes got %0b/%0d/%0b/%0d want 0/0/0/1",
               stale, state, stop_valid, vote_count);
    end
    repeat (99) @(negedge clk);
    send(1'b1, 10000);
    n_cmp++;
    if ({stale, vote_count} !== {1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL to_tie: stale/votes got %0b/%0d want 0/2", stale, vote_count);
    end
  endtask

  task automatic test_clear();
    do_reset();
    repeat (8) send(1'b1, 10000);
    clear = 1'b1; det_valid = 1'b1; det_crossing = 1'b1; white_count = 17'd10000;
    @(negedge clk);
    clear = 1'b0; det_valid = 1'b0; det_crossing = 1'b0; white_count = '0;
    n_cmp++;
    if ({state, stop, stop_valid, vote_count, stale} !== {3'd0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear: state/stop/sv/votes/stale got %0d/%0b/%0b/%0d/%0b want 0/0/0/0/0",
               state, stop, stop_valid, vote_count, stale);
    end
    repeat (7) send(1'b1, 10000);
    n_cmp++;
    if ({state, vote_count} !== {3'd0, 4'd7}) begin
      n_fail++;
      $display("FAIL clear_fill: state/votes got %0d/%0d want 0/7", state, vote_count);
    end
    send(1'b1, 10000);
    n_cmp++;
    if ({state, stop} !== {3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_refill: state/stop got %0d/%0b want 2/1", state, stop);
    end
  endtask

  task automatic test_reset_hold();
    do_reset();
    repeat (8) send(1'b1, 10000);
    repeat (6) send(1'b0, 10000);
    n_cmp++;
    if ({state, stop} !== {3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_hold_pre: state/stop got %0d/%0b want 3/1", state, stop);
    end
    do_reset();
    n_cmp++;
    if ({state, stop, vote_count} !== {3'd0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_hold: state/stop/votes got %0d/%0b/%0d want 0/0/0", state, stop, vote_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1; clear = 1'b0; det_valid = 1'b0; det_crossing = 1'b0; white_count = '0;
    test_reset();
    test_fill_stop();
    test_hysteresis();
    test_hold();
    test_white_band();
    test_timeout();
    test_clear();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
